// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the debug-unit run controller: command opcodes and
// controller states.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_STEP  = 2'b01,
        OP_RUN   = 2'b10,
        OP_SETBP = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

endpackage

// File: rtl/bp_match.sv
// Single-address breakpoint register and comparator. The resume flag lets the
// instruction at a breakpoint PC commit once when execution is restarted there.
module bp_match #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_bp,
    input  logic [XLEN-3:0] set_addr,
    input  logic            set_valid,
    input  logic            arm,
    input  logic            commit,
    input  logic [XLEN-1:0] current_pc,
    output logic            bpm
);

    logic [XLEN-3:0] bp_addr;
    logic            bp_valid;
    logic            resume;

    // Word-aligned address: the two low bits are implicitly zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_addr  <= '0;
            bp_valid <= 1'b0;
            resume   <= 1'b0;
        end else begin
            if (set_bp) begin
                bp_addr  <= set_addr;
                bp_valid <= set_valid;
            end
            if (arm) begin
                resume <= 1'b1;
            end else if (commit) begin
                resume <= 1'b0;
            end
        end
    end

    assign bpm = bp_valid && (current_pc == {bp_addr, 2'b00}) && !resume;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller gating the core's commit enable.
// Breakpoint support is built only when RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [XLEN-1:0] cmd_arg,
    input  logic [XLEN-1:0] current_pc,
    output logic            cpu_en,
    output logic            halted,
    output logic            bp_hit,
    output logic            cmd_err,
    output logic [XLEN-1:0] retired
);

    state_e          state, state_nxt;
    cmd_op_e         op;
    logic            idle;
    logic            bpm;
    logic            start_cmd;
    logic            stop_acc;
    logic            step_last;
    logic [XLEN-1:0] step_left;

    assign op        = cmd_op_e'(cmd_op);
    assign idle      = (state == ST_IDLE);
    assign start_cmd = idle && cmd_valid && ((op == OP_STEP) || (op == OP_RUN));
    assign stop_acc  = !idle && cmd_valid && (op == OP_STOP);
    assign step_last = (state == ST_STEP) && cpu_en && (step_left == XLEN'(1));

`ifdef RUN_CTRL_BP_EN
    logic set_bp;
    logic bp_hit_q;

    assign set_bp = idle && cmd_valid && (op == OP_SETBP);

    bp_match #(
        .XLEN(XLEN)
    ) u_bp_match (
        .clk        (clk),
        .rst        (rst),
        .set_bp     (set_bp),
        .set_addr   (cmd_arg[XLEN-1:2]),
        .set_valid  (~cmd_arg[0]),
        .arm        (start_cmd),
        .commit     (cpu_en),
        .current_pc (current_pc),
        .bpm        (bpm)
    );

    // Sticky until the next non-SET_BP command is accepted while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_hit_q <= 1'b0;
        end else if (bpm && !idle) begin
            bp_hit_q <= 1'b1;
        end else if (idle && cmd_valid && (op != OP_SETBP)) begin
            bp_hit_q <= 1'b0;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic pc_unused;

    assign pc_unused = ^current_pc;
    assign bpm       = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaulting state_nxt up front covers every path, so no latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && (op == OP_STEP)) begin
                    state_nxt = ST_STEP;
                end else if (cmd_valid && (op == OP_RUN)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_STEP, ST_RUN: begin
                if (stop_acc || bpm || step_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_en    = (state != ST_IDLE) && !bpm;
        halted    = (state == ST_IDLE);
        cmd_ready = 1'b1;
    end

    // A STEP of zero is treated as a single step.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_left <= '0;
            retired   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= cmd_valid && !idle && (op != OP_STOP);
            if (start_cmd && (op == OP_STEP)) begin
                step_left <= (cmd_arg == '0) ? XLEN'(1) : cmd_arg;
            end else if ((state == ST_STEP) && cpu_en) begin
                step_left <= step_left - XLEN'(1);
            end
            if (cpu_en) begin
                retired <= retired + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a cycle model of the run-control rules
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cpu_run_ctrl;
    import cpu_dbg_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [XLEN-1:0] cmd_arg;
    logic [XLEN-1:0] pc;
    logic            cpu_en;
    logic            halted;
    logic            bp_hit;
    logic            cmd_err;
    logic [XLEN-1:0] retired;

    int errors = 0;
    int checks = 0;
    int commits = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .current_pc (pc),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .cmd_err    (cmd_err),
        .retired    (retired)
    );

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = halted, 1 = counted stepping, 2 = free running.
    int          m_mode;
    int unsigned m_budget;
    logic        m_skip;
    logic        m_bp_on;
    logic [31:0] m_bp_addr;
    logic        m_hit;
    logic        m_err;
    logic [31:0] m_ret;
    bit          started = 1'b0;

    function automatic logic m_match();
`ifdef RUN_CTRL_BP_EN
        return m_bp_on && (pc == m_bp_addr) && !m_skip;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_en();
        return (m_mode != 0) && !m_match();
    endfunction

    always @(posedge clk) begin : model_p
        int          mode;
        int unsigned budget;
        logic        skip, bp_on, hit, err, en, match;
        logic [31:0] bp_addr, ret;
        mode = m_mode; budget = m_budget; skip = m_skip; bp_on = m_bp_on;
        bp_addr = m_bp_addr; hit = m_hit; ret = m_ret;
        if (rst) begin
            mode = 0; budget = 0; skip = 1'b0; bp_on = 1'b0; bp_addr = '0;
            hit = 1'b0; err = 1'b0; ret = '0;
        end else begin
            en    = m_en();
            match = m_match();
            err   = cmd_valid && (mode != 0) && (cmd_op != OP_STOP);
            if (mode == 0) begin
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        OP_STEP: begin
                            budget = (cmd_arg == 0) ? 1 : cmd_arg;
                            skip = 1'b1; mode = 1; hit = 1'b0;
                        end
                        OP_RUN: begin
                            skip = 1'b1; mode = 2; hit = 1'b0;
                        end
                        OP_SETBP: begin
`ifdef RUN_CTRL_BP_EN
                            bp_addr = cmd_arg & 32'hFFFF_FFFC;
                            bp_on   = !cmd_arg[0];
`endif
                        end
                        default: hit = 1'b0;
                    endcase
                end
            end else begin
                if (en) begin
                    ret  = ret + 1;
                    skip = 1'b0;
                end
                if (match) hit = 1'b1;
                if ((cmd_valid && (cmd_op == OP_STOP)) || match) begin
                    mode = 0;
                end else if ((mode == 1) && en) begin
                    budget = budget - 1;
                    if (budget == 0) mode = 0;
                end
            end
        end
        m_mode <= mode; m_budget <= budget; m_skip <= skip; m_bp_on <= bp_on;
        m_bp_addr <= bp_addr; m_hit <= hit; m_err <= err; m_ret <= ret;
        if (rst) started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("cpu_en", {31'b0, cpu_en}, {31'b0, m_en()});
            check("halted", {31'b0, halted}, {31'b0, m_mode == 0});
            check("bp_hit", {31'b0, bp_hit}, {31'b0, m_hit});
            check("cmd_err", {31'b0, cmd_err}, {31'b0, m_err});
            check("retired", retired, m_ret);
            check("cmd_ready", {31'b0, cmd_ready}, 32'd1);
        end
    end

    // One cycle; the bench plays the core, advancing PC on each commit edge.
    task automatic tick();
        logic en;
        @(negedge clk);
        en = cpu_en;
        @(posedge clk);
        #1;
        if (en) begin
            pc = pc + 4;
            commits++;
        end
    endtask

    task automatic send(input cmd_op_e op, input logic [XLEN-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_STOP;
        cmd_arg   = '0;
    endtask

    task automatic wait_halt(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit ok;
        int c0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_STOP; cmd_arg = '0; pc = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_halted", {31'b0, halted}, 32'd1);
        check("rst_retired", retired, 32'd0);
        check("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        check("rst_bp_hit", {31'b0, bp_hit}, 32'd0);

        // STEP 3 from PC 0
        pc = '0; c0 = commits;
        send(OP_STEP, 32'd3);
        wait_halt(20, ok);
        check("step3_halt", {31'b0, ok}, 32'd1);
        check("step3_commits", commits - c0, 32'd3);
        check("step3_retired", retired, 32'd3);
        check("step3_pc", pc, 32'h0000_000C);

        // STEP 0 behaves as STEP 1
        c0 = commits;
        send(OP_STEP, 32'd0);
        wait_halt(20, ok);
        check("step0_halt", {31'b0, ok}, 32'd1);
        check("step0_commits", commits - c0, 32'd1);
        check("step0_retired", retired, 32'd4);

        // Breakpoint at 0x10, RUN from 0
        pc = '0;
        send(OP_SETBP, 32'h10);
        c0 = commits;
        send(OP_RUN, 32'd0);
`ifdef RUN_CTRL_BP_EN
        wait_halt(40, ok);
        check("bp_halt", {31'b0, ok}, 32'd1);
        check("bp_commits", commits - c0, 32'd4);
        check("bp_retired", retired, 32'd8);
        check("bp_flag", {31'b0, bp_hit}, 32'd1);
        check("bp_pc", pc, 32'h10);
        send(OP_RUN, 32'd0);
        check("bp_resume_clear", {31'b0, bp_hit}, 32'd0);
        c0 = commits;
        tick();
        check("bp_resume_commit", commits - c0, 32'd1);
        check("bp_resume_pc", pc, 32'h14);
`else
        for (int i = 0; i < 8; i++) tick();
        check("nobp_running", {31'b0, halted}, 32'd0);
        check("nobp_commits", commits - c0, 32'd8);
        check("nobp_flag", {31'b0, bp_hit}, 32'd0);
`endif
        send(OP_STOP, 32'd0);
        check("bp_stop_halted", {31'b0, halted}, 32'd1);

        // Command while busy, then STOP
        send(OP_RUN, 32'd0);
        tick(); tick();
        send(OP_STEP, 32'd5);
        check("err_pulse", {31'b0, cmd_err}, 32'd1);
        check("err_still_run", {31'b0, halted}, 32'd0);
        tick();
        check("err_one_cycle", {31'b0, cmd_err}, 32'd0);
        c0 = commits;
        send(OP_STOP, 32'd0);
        check("stop_commit_in_accept", commits - c0, 32'd1);
        check("stop_halted", {31'b0, halted}, 32'd1);
        check("stop_bp_hit", {31'b0, bp_hit}, 32'd0);
        c0 = commits;
        tick();
        check("stop_no_more", commits - c0, 32'd0);

        // SET_BP with flag bit set disables the breakpoint
        send(OP_SETBP, 32'h11);
        pc = '0;
        send(OP_RUN, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("bpdis_running", {31'b0, halted}, 32'd0);
        check("bpdis_pc", pc, 32'h20);
        send(OP_STOP, 32'd0);

`ifdef RUN_CTRL_BP_EN
        // Breakpoint during STEP, then single-step off it
        send(OP_SETBP, 32'h8);
        pc = '0; c0 = commits;
        send(OP_STEP, 32'd10);
        wait_halt(30, ok);
        check("stepbp_halt", {31'b0, ok}, 32'd1);
        check("stepbp_commits", commits - c0, 32'd2);
        check("stepbp_flag", {31'b0, bp_hit}, 32'd1);
        c0 = commits;
        send(OP_STEP, 32'd1);
        wait_halt(10, ok);
        check("stepoff_commits", commits - c0, 32'd1);
        check("stepoff_pc", pc, 32'hC);
        check("stepoff_flag", {31'b0, bp_hit}, 32'd0);
`endif

        // Reset clears the breakpoint; reset mid-RUN at retired=7
        send(OP_SETBP, 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pc = '0;
        send(OP_RUN, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (retired === 32'd7) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("rstrun_reach7", {31'b0, ok}, 32'd1);
        check("rstrun_running", {31'b0, halted}, 32'd0);
        rst = 1'b1;
        tick();
        check("rstrun_retired", retired, 32'd0);
        check("rstrun_halted", {31'b0, halted}, 32'd1);
        check("rstrun_cpu_en", {31'b0, cpu_en}, 32'd0);
        rst = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
